// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - iterative AES encryption round controller
// Runs initial AddRoundKey then NR single-cycle passes through an external round datapath.
module aes_round_sequencer #(
  parameter int NR = 10,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_block,
  input  logic          key_ready,
  output logic [CW-1:0] rk_idx,
  input  logic [127:0]  rk_data,
  output logic [127:0]  dp_state,
  output logic [127:0]  dp_key,
  output logic          dp_last,
  input  logic [127:0]  dp_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_block,
  output logic          busy,
  output logic [CW-1:0] round_cnt
);

  generate
    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
      $error("aes_round_sequencer: NR must be 10, 12 or 14");
    end
    if ((1 << CW) <= NR) begin : g_bad_cw
      $error("aes_round_sequencer: CW too narrow for NR");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  localparam logic [CW-1:0] NR_C = CW'(NR);

  fsm_t          fsm, fsm_nxt;
  logic [127:0]  state_reg, state_nxt;
  logic [127:0]  out_reg, out_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      state_reg <= '0;
      out_reg   <= '0;
      cnt       <= '0;
    end else begin
      fsm       <= fsm_nxt;
      state_reg <= state_nxt;
      out_reg   <= out_nxt;
      cnt       <= cnt_nxt;
    end
  end

  always_comb begin
    fsm_nxt   = fsm;
    state_nxt = state_reg;
    out_nxt   = out_reg;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    rk_idx    = '0;
    case (fsm)
      IDLE: begin
        // rk_idx is 0 here, so rk_data is round key 0 for the initial whitening.
        in_ready = key_ready;
        if (in_valid && key_ready) begin
          state_nxt = in_block ^ rk_data;
          cnt_nxt   = CW'(1);
          fsm_nxt   = ROUND;
        end
      end
      ROUND: begin
        rk_idx = cnt;
        if (cnt == NR_C) begin
          out_nxt = dp_result;
          cnt_nxt = '0;
          fsm_nxt = DONE;
        end else begin
          state_nxt = dp_result;
          cnt_nxt   = cnt + CW'(1);
        end
      end
      DONE: begin
        // No acceptance on the handshake edge; IDLE must be visited first.
        if (out_ready) begin
          fsm_nxt = IDLE;
        end
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  assign dp_state  = state_reg;
  assign dp_key    = rk_data;
  assign dp_last   = (fsm == ROUND) && (cnt == NR_C);
  assign out_valid = (fsm == DONE);
  assign out_block = out_reg;
  assign busy      = (fsm != IDLE);
  assign round_cnt = cnt;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - self-checking bench for aes_round_sequencer
// Supplies AES-128 key table and round units; checks against an in-bench encryption model.
module tb_aes_round_sequencer;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_block = '0;
  logic         key_ready = 1'b0;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic [127:0] dp_state;
  logic [127:0] dp_key;
  logic         dp_last;
  logic [127:0] dp_result;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_block;
  logic         busy;
  logic [3:0]   round_cnt;

  logic [127:0] rk_tab [0:15];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  aes_round_sequencer #(.NR(10), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .key_ready(key_ready), .rk_idx(rk_idx), .rk_data(rk_data),
    .dp_state(dp_state), .dp_key(dp_key), .dp_last(dp_last), .dp_result(dp_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .busy(busy), .round_cnt(round_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from first principles: GF(2^8) inverse (a^254) then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv, x, r, s;
    inv = 8'h01;
    x = a;
    for (int i = 1; i < 8; i++) begin
      x = gmul(x, x);
      inv = gmul(inv, x);
    end
    s = inv;
    r = inv;
    for (int i = 0; i < 4; i++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0] b [0:15];
    logic [7:0] t [0:15];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) t[rr+4*c] = b[rr+4*((c+rr)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
    return r ^ k;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk_tab[0];
    for (int r = 1; r < 10; r++) s = aes_round(s, rk_tab[r], 1'b0);
    return aes_round(s, rk_tab[10], 1'b1);
  endfunction

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int r = 11; r < 16; r++) rk_tab[r] = '0;
  endtask

  assign rk_data = rk_tab[rk_idx];
  always_comb dp_result = aes_round(dp_state, dp_key, dp_last);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 encrypting round m_k, 2 holding ciphertext.
  int           m_mode = 0;
  int           m_k = 0;
  logic [127:0] m_st = '0;
  logic [127:0] m_out = '0;
  logic [127:0] m_exp = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_k = 0; m_st = '0; m_out = '0;
    end else begin
      case (m_mode)
        0: if (in_valid && key_ready) begin
             m_mode = 1; m_k = 1;
             m_st = in_block ^ rk_tab[0];
             m_exp = aes_encrypt(in_block);
           end
        1: if (m_k == 10) begin
             m_mode = 2; m_k = 0; m_out = m_exp;
           end else begin
             m_st = aes_round(m_st, rk_tab[m_k], 1'b0);
             m_k++;
           end
        default: if (out_ready) m_mode = 0;
      endcase
    end
  end

  always @(posedge clk) begin
    #2;
    chk("in_ready", in_ready, (m_mode == 0) && key_ready);
    chk("busy", busy, m_mode != 0);
    chk("out_valid", out_valid, m_mode == 2);
    chk("out_block", out_block, m_out);
    chk("round_cnt", round_cnt, m_k);
    chk("rk_idx", rk_idx, m_k);
    chk("dp_last", dp_last, (m_mode == 1) && (m_k == 10));
    chk("dp_state", dp_state, m_st);
    chk("dp_key", dp_key, rk_tab[m_k]);
  end

  task automatic wait_out(output int at, input string name);
    at = -1;
    for (int i = 0; i < 40 && at < 0; i++) begin
      @(negedge clk);
      if (out_valid) at = cyc;
    end
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL %s: out_valid never rose, got 0 expected 1", name);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, at, at2, nlast, guard, seen;
    bit accd;
    int seq[$];
    set_key('0);
    repeat (3) @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset round_cnt", round_cnt, 0);
    chk("reset out_block", out_block, 0);
    rst_n = 1'b1;

    // FIPS-197 C.1 with key_ready gating
    set_key(KEY1);
    in_block = PT1; in_valid = 1'b1; key_ready = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("gate in_ready", in_ready, 0);
      chk("gate busy", busy, 0);
      chk("gate rk_idx", rk_idx, 0);
    end
    key_ready = 1'b1;
    @(negedge clk);
    acc = cyc;
    chk("accept busy", busy, 1);
    in_valid = 1'b0;
    at = -1; nlast = 0;
    for (int i = 0; i < 30 && at < 0; i++) begin
      if (out_valid) at = cyc;
      else begin
        seq.push_back(int'(rk_idx));
        if (dp_last) begin
          nlast++;
          chk("last rk_idx", rk_idx, 10);
          chk("round10 key", dp_key, RK10);
        end
        @(negedge clk);
      end
    end
    chk("latency", at - acc, 10);
    chk("fips ct", out_block, CT1);
    chk("rk seq len", seq.size(), 10);
    foreach (seq[j]) chk("rk seq", seq[j], j + 1);
    chk("dp_last count", nlast, 1);
    @(negedge clk);
    chk("one-cycle valid", out_valid, 0);
    chk("idle after hs", busy, 0);

    // Backpressure
    out_ready = 1'b0; in_block = PT1; in_valid = 1'b1;
    @(negedge clk);
    chk("bp accept", busy, 1);
    in_block = {$urandom, $urandom, $urandom, $urandom};
    wait_out(at, "bp");
    repeat (5) begin
      @(negedge clk);
      chk("bp valid", out_valid, 1);
      chk("bp block", out_block, CT1);
      chk("bp in_ready", in_ready, 0);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("bp idle", busy, 0);
    chk("bp valid low", out_valid, 0);

    // Back-to-back, second block all-zero under all-zero key
    set_key('0);
    in_block = {$urandom, $urandom, $urandom, $urandom}; in_valid = 1'b1;
    @(negedge clk);
    in_block = '0;
    wait_out(at, "b2b first");
    wait_out(at2, "b2b second");
    in_valid = 1'b0;
    chk("b2b spacing", at2 - at, 12);
    chk("b2b ct", out_block, CT0);
    @(negedge clk);

    // Mid-operation reset
    set_key(KEY1);
    in_block = PT1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (round_cnt == 4'd5) seen = 1; else @(negedge clk);
    end
    chk("reached round 5", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async out_valid", out_valid, 0);
    chk("async busy", busy, 0);
    chk("async round_cnt", round_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) begin
      @(negedge clk);
      chk("no stale output", out_valid, 0);
    end
    in_block = PT1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(at, "post-reset");
    chk("post-reset ct", out_block, CT1);
    @(negedge clk);

    // Randomized blocks, keys and handshakes
    for (int b = 0; b < 10; b++) begin
      guard = 0;
      while (busy && guard < 40) begin @(negedge clk); guard++; end
      set_key({$urandom, $urandom, $urandom, $urandom});
      accd = 1'b0;
      guard = 0;
      while (guard < 300) begin
        guard++;
        in_valid = 1'($urandom % 2);
        in_block = {$urandom, $urandom, $urandom, $urandom};
        if (!accd) key_ready = ($urandom % 4) != 0;
        out_ready = 1'($urandom % 2);
        @(negedge clk);
        if (busy) accd = 1'b1;
        else if (accd) break;
      end
      in_valid = 1'b0;
      if (guard >= 300) begin
        checks++; errors++;
        $display("FAIL random block %0d: did not complete, got busy expected idle", b);
      end
    end
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
